// File: rtl/vga_timing_gen.sv
// VGA raster timing: hsync/vsync/video_on and pixel coordinates, free-running while the PLL is locked.
// Latency: every output is registered 1 clk after its counter value; no backpressure, forced idle when unlocked.
module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FRONT  = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BACK   = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 33
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_locked,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       frame_start,
  output logic       line_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
  localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_S = 10'(H_ACTIVE + H_FRONT);
  localparam logic [9:0] H_SYNC_E = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] V_SYNC_S = 10'(V_ACTIVE + V_FRONT);
  localparam logic [9:0] V_SYNC_E = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_nxt;
  logic [9:0] h_cnt, v_cnt;
  logic       counting;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    counting  = 1'b0;
    case (state)
      IDLE: if (pll_locked) state_nxt = RUN;
      RUN: begin
        if (pll_locked) counting  = 1'b1;
        else            state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Counters sit at (0,0) whenever not counting, so a lock loss restarts the raster cleanly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!counting) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_MAX) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_MAX) ? '0 : v_cnt + 10'd1;
    end else begin
      h_cnt <= h_cnt + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else if (counting) begin
      hsync       <= !((h_cnt >= H_SYNC_S) && (h_cnt <= H_SYNC_E));
      vsync       <= !((v_cnt >= V_SYNC_S) && (v_cnt <= V_SYNC_E));
      video_on    <= (h_cnt < H_ACT) && (v_cnt < V_ACT);
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
      frame_start <= (h_cnt == '0) && (v_cnt == '0);
      line_start  <= (h_cnt == '0);
    end else begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen with a shrunken raster (30x15 clocks, 450 clks/frame):
// the driver queues the expected outputs for each edge, the monitor pops and compares.
module tb_vga_timing_gen;

  localparam int HT = 30;   // 16 + 4 + 6 + 4
  localparam int VT = 15;   // 8 + 2 + 2 + 3

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       von;
    logic       fs;
    logic       ls;
    logic [9:0] x;
    logic [9:0] y;
  } exp_t;

  typedef struct {
    int   cyc;
    exp_t e;
  } sb_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       hsync, vsync, video_on, frame_start, line_start;
  logic [9:0] pixel_x, pixel_y;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   epoch = 0;
  sb_t  q[$];
  logic m_run;
  int   m_n;
  exp_t last_e;

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FRONT(4), .H_SYNC(6), .H_BACK(4),
    .V_ACTIVE(8),  .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked),
    .hsync(hsync), .vsync(vsync), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y),
    .frame_start(frame_start), .line_start(line_start)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s at cyc %0d: got %0d, want %0d", nm, cyc, act, want);
    end
  endtask

  function automatic exp_t idle_e();
    exp_t d;
    d = '0;
    d.hs = 1'b1;
    d.vs = 1'b1;
    return d;
  endfunction

  // Hand-derived windows: hsync low x in 20..25, vsync low y in 10..11, visible x<16, y<8.
  function automatic exp_t decode(input int n);
    exp_t d;
    int x, y;
    x = n % HT;
    y = (n / HT) % VT;
    d.hs  = !(x >= 20 && x <= 25);
    d.vs  = !(y >= 10 && y <= 11);
    d.von = (x < 16) && (y < 8);
    d.fs  = (x == 0) && (y == 0);
    d.ls  = (x == 0);
    d.x   = 10'(x);
    d.y   = 10'(y);
    return d;
  endfunction

  task automatic step(input logic l, input logic rel);
    sb_t s;
    @(posedge clk);
    #1;
    if (rel) rst_n = 1'b1;
    pll_locked = l;
    s.cyc = cyc + 1;
    s.e   = (m_run && l) ? decode(m_n) : idle_e();
    q.push_back(s);
    last_e = s.e;
    if (m_run && l) m_n++;
    else            m_n = 0;
    m_run = l;
    if (!l) epoch++;
  endtask

  task automatic chk_idle_now(input string tag);
    chk({tag, "_hsync"},   32'(hsync),       32'd1);
    chk({tag, "_vsync"},   32'(vsync),       32'd1);
    chk({tag, "_video"},   32'(video_on),    32'd0);
    chk({tag, "_px"},      32'(pixel_x),     32'd0);
    chk({tag, "_py"},      32'(pixel_y),     32'd0);
    chk({tag, "_fs"},      32'(frame_start), 32'd0);
    chk({tag, "_ls"},      32'(line_start),  32'd0);
  endtask

  // Reset asserted between edges: outputs must go idle without any clock.
  task automatic do_reset(input string tag);
    @(posedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    epoch++;
    m_run = 1'b0;
    m_n   = 0;
    #1;
    chk_idle_now(tag);
    repeat (2) @(posedge clk);
    #1;
    chk_idle_now({tag, "_held"});
  endtask

  // Monitor: per-cycle scoreboard plus run-length checks of the sync pulses and frame period.
  logic prev_hs = 1'b1, prev_vs = 1'b1;
  int   hs_len, hs_ep, vs_len, vs_ep, fs_cyc, fs_ep;
  logic fs_have = 1'b0;

  always @(negedge clk) begin
    sb_t s;
    if (q.size() > 0 && q[0].cyc == cyc) begin
      s = q.pop_front();
      chk("hsync",       32'(hsync),       32'(s.e.hs));
      chk("vsync",       32'(vsync),       32'(s.e.vs));
      chk("video_on",    32'(video_on),    32'(s.e.von));
      chk("frame_start", 32'(frame_start), 32'(s.e.fs));
      chk("line_start",  32'(line_start),  32'(s.e.ls));
      chk("pixel_x",     32'(pixel_x),     32'(s.e.x));
      chk("pixel_y",     32'(pixel_y),     32'(s.e.y));
    end
    if (!hsync) begin
      if (prev_hs) begin hs_len = 1; hs_ep = epoch; end
      else hs_len++;
    end else if (!prev_hs && hs_ep == epoch) begin
      chk("hsync_width", 32'(hs_len), 32'd6);
    end
    if (!vsync) begin
      if (prev_vs) begin vs_len = 1; vs_ep = epoch; end
      else vs_len++;
    end else if (!prev_vs && vs_ep == epoch) begin
      chk("vsync_width", 32'(vs_len), 32'd60);
    end
    if (frame_start === 1'b1) begin
      if (fs_have && fs_ep == epoch) chk("frame_period", 32'(cyc - fs_cyc), 32'd450);
      fs_have = 1'b1;
      fs_cyc  = cyc;
      fs_ep   = epoch;
    end
    prev_hs = hsync;
    prev_vs = vsync;
  end

  initial begin
    int guard;
    rst_n      = 1'b0;
    pll_locked = 1'b1;
    m_run      = 1'b0;
    m_n        = 0;
    last_e     = idle_e();
    repeat (3) @(posedge clk);
    #1;
    chk_idle_now("reset");

    // Release with lock held: two full frames plus a few clocks across the wrap.
    step(1'b1, 1'b1);
    repeat (2 * HT * VT + 10) step(1'b1, 1'b0);

    // Lose lock while pixel (10,5) is presented, then re-lock.
    guard = 0;
    while (!(last_e.x == 10'd10 && last_e.y == 10'd5) && guard < 2 * HT * VT) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_drop_point", 32'(last_e.x), 32'd10);
    repeat (3) step(1'b0, 1'b0);
    repeat (40) step(1'b1, 1'b0);

    // Async reset in the middle of an hsync pulse.
    guard = 0;
    while (!(last_e.hs == 1'b0 && last_e.x == 10'd22) && guard < 2 * HT * VT) begin
      step(1'b1, 1'b0);
      guard++;
    end
    chk("reach_hsync_point", 32'(last_e.x), 32'd22);
    do_reset("rst_mid_hsync");

    // Release with lock low, idle a while, then lock and run past a frame boundary.
    step(1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b0);
    repeat (HT * VT + 60) step(1'b1, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
